// File: rtl/legv8_operand_fetch.sv
// LEGv8 operand-fetch stage: 32x64 register file (XZR, write-through bypass) feeding a valid/ready output slot.
// Optional LEGV8_OPFETCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module legv8_operand_fetch #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ZERO_REG    = 31,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           Instruction,
    input  logic                  Reg2Loc,
    input  logic                  ALUSrc,
    input  logic [1:0]            ALUOp_in,
    input  logic [DATA_WIDTH-1:0] SignExt_imm,
    input  logic                  flush,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [1:0]            ALUOp,
    output logic [10:0]           Opcode_field,
    output logic [DATA_WIDTH-1:0] StoreData
`ifdef LEGV8_OPFETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];
    logic [4:0]            rn_idx, r2_idx;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic                  load;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, sd_q, sd_d;
    logic [1:0]            aluop_q, aluop_d;
    logic [10:0]           opc_q, opc_d;

    // Shift-amount bits are consumed by the ALU stage from elsewhere, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instruction[15:10];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && WriteReg != ZERO_IDX) regs_d[WriteReg] = WriteData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rn_idx = Instruction[9:5];
    assign r2_idx = Reg2Loc ? Instruction[4:0] : Instruction[20:16];

    // XZR check is applied last so it overrides a bypassed write to index ZERO_REG.
    always_comb begin
        rd1 = regs_q[rn_idx];
        if (RegWrite && WriteReg == rn_idx) rd1 = WriteData;
        if (rn_idx == ZERO_IDX) rd1 = '0;
        rd2 = regs_q[r2_idx];
        if (RegWrite && WriteReg == r2_idx) rd2 = WriteData;
        if (r2_idx == ZERO_IDX) rd2 = '0;
    end

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        aluop_d = aluop_q;
        opc_d   = opc_q;
        if (load) begin
            valid_d = 1'b1;
            a_d     = rd1;
            b_d     = ALUSrc ? SignExt_imm : rd2;
            sd_d    = rd2;
            aluop_d = ALUOp_in;
            opc_d   = Instruction[31:21];
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            aluop_q <= '0;
            opc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            aluop_q <= aluop_d;
            opc_q   <= opc_d;
        end
    end

    assign out_valid    = valid_q;
    assign A            = a_q;
    assign B            = b_q;
    assign StoreData    = sd_q;
    assign ALUOp        = aluop_q;
    assign Opcode_field = opc_q;

`ifdef LEGV8_OPFETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !out_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_legv8_operand_fetch.sv
// Bench for legv8_operand_fetch: directed literal checks, then randomized traffic against a behavioural model.
module tb_legv8_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] Instruction;
    logic        Reg2Loc, ALUSrc;
    logic [1:0]  ALUOp_in;
    logic [63:0] SignExt_imm;
    logic        flush, RegWrite;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic        out_valid, out_ready;
    logic [63:0] A, B, StoreData;
    logic [1:0]  ALUOp;
    logic [10:0] Opcode_field;
`ifdef LEGV8_OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    legv8_operand_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp_in(ALUOp_in),
        .SignExt_imm(SignExt_imm), .flush(flush), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
        .ALUOp(ALUOp), .Opcode_field(Opcode_field), .StoreData(StoreData)
`ifdef LEGV8_OPFETCH_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Architectural view: register contents plus the single output slot.
    logic [63:0] m_regs [32];
    logic        m_valid;
    logic [63:0] m_a, m_b, m_sd;
    logic [1:0]  m_aluop;
    logic [10:0] m_opc;
    logic [31:0] m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (RegWrite && WriteReg == idx) return WriteData;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] mk_r(input logic [10:0] opc, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rdst);
        return {opc, rm, 6'd0, rn, rdst};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_sd = '0; m_aluop = '0; m_opc = '0; m_stall = '0;
    endtask

    // One clock: evaluate the spec rules on the current inputs, then commit at the edge.
    task automatic step();
        logic        nv;
        logic [63:0] na, nb, nsd, r2v;
        logic [1:0]  nal;
        logic [10:0] nop;
        logic [31:0] nst;
        logic [4:0]  r2;
        nv = m_valid; na = m_a; nb = m_b; nsd = m_sd; nal = m_aluop; nop = m_opc; nst = m_stall;
        r2  = Reg2Loc ? Instruction[4:0] : Instruction[20:16];
        r2v = rd(r2);
        if (in_valid && (!m_valid || out_ready) && !flush) begin
            nv = 1'b1; na = rd(Instruction[9:5]); nsd = r2v;
            nb = ALUSrc ? SignExt_imm : r2v; nal = ALUOp_in; nop = Instruction[31:21];
        end else if (flush || out_ready) begin
            nv = 1'b0;
        end
        if (m_valid && !out_ready && m_stall != 32'hFFFF_FFFF) nst = m_stall + 32'd1;
        @(posedge clk);
        if (RegWrite && WriteReg != 5'd31) m_regs[WriteReg] = WriteData;
        m_valid = nv; m_a = na; m_b = nb; m_sd = nsd; m_aluop = nal; m_opc = nop; m_stall = nst;
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; Instruction = '0; Reg2Loc = 0; ALUSrc = 0; ALUOp_in = 0; SignExt_imm = '0;
        flush = 0; RegWrite = 0; WriteReg = '0; WriteData = '0; out_ready = 1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic alusrc, input logic [1:0] aop,
                         input logic [63:0] imm);
        in_valid = 1; Instruction = ins; Reg2Loc = 0; ALUSrc = alusrc; ALUOp_in = aop; SignExt_imm = imm;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [63:0] data);
        RegWrite = 1; WriteReg = idx; WriteData = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_A", A, 64'd0);
        chk("rst_B", B, 64'd0);
        chk("rst_StoreData", StoreData, 64'd0);
        chk("rst_ALUOp", 64'(ALUOp), 64'd0);
        chk("rst_Opcode", 64'(Opcode_field), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("StoreData", StoreData, m_sd);
            chk("ALUOp", 64'(ALUOp), 64'(m_aluop));
            chk("Opcode_field", 64'(Opcode_field), 64'(m_opc));
`ifdef LEGV8_OPFETCH_STALL_CNT_EN
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        end
    end

    function automatic logic [4:0] pick_idx();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 5'd31 : 5'(r);
    endfunction

    localparam logic [31:0] ADD_123  = 32'h8B03_0041;  // ADD X1,X2,X3
    localparam logic [31:0] ADDI_12  = 32'h9100_3041;  // ADDI X1,X2,#12

    initial begin
        logic [31:0] ins;
        set_idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_A", A, 64'd0);
        cmp_en = 1'b1;

        issue(ADD_123, 0, 2'b10, '0);
        step();
        chk("add_zero_valid", 64'(out_valid), 64'd1);
        chk("add_zero_A", A, 64'd0);
        chk("add_zero_B", B, 64'd0);
        chk("add_zero_opc", 64'(Opcode_field), 64'h458);

        set_idle(); wr(5'd2, 64'd5); step();
        set_idle(); wr(5'd3, 64'd7); step();
        set_idle(); issue(ADD_123, 0, 2'b10, '0); step();
        chk("add_A", A, 64'd5);
        chk("add_B", B, 64'd7);
        chk("add_ALUOp", 64'(ALUOp), 64'd2);
        chk("add_StoreData", StoreData, 64'd7);

        set_idle(); issue(ADDI_12, 1, 2'b10, 64'd12); step();
        chk("addi_B", B, 64'd12);
        chk("addi_A", A, 64'd5);
        chk("addi_opc", 64'(Opcode_field), 64'h488);

        set_idle(); issue(ADD_123, 0, 2'b10, '0); wr(5'd2, 64'd9); step();
        chk("bypass_A", A, 64'd9);

        set_idle(); wr(5'd31, 64'hFFFF); step();
        set_idle(); issue(mk_r(11'h458, 5'd3, 5'd31, 5'd1), 0, 2'b10, '0); wr(5'd31, 64'hFFFF); step();
        chk("xzr_A", A, 64'd0);
        chk("xzr_B", B, 64'd7);

        set_idle(); issue(ADD_123, 0, 2'b10, '0); step();
        issue(ADDI_12, 1, 2'b00, 64'd12); out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_A", A, 64'd9);
            chk("stall_B", B, 64'd7);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
        end
`ifdef LEGV8_OPFETCH_STALL_CNT_EN
        chk("stall_count3", 64'(stall_cycles), 64'd3);
`endif
        out_ready = 1; step();
        chk("unstall_B", B, 64'd12);
        chk("unstall_ALUOp", 64'(ALUOp), 64'd0);
        set_idle(); step();
        chk("drain_valid", 64'(out_valid), 64'd0);

        set_idle(); issue(ADD_123, 0, 2'b10, '0); flush = 1; step();
        chk("flush_in_valid", 64'(out_valid), 64'd0);
        set_idle(); issue(ADD_123, 0, 2'b10, '0); step();
        issue(ADDI_12, 1, 2'b10, 64'd12); flush = 1; out_ready = 0; step();
        chk("flush_held_valid", 64'(out_valid), 64'd0);

        set_idle(); issue(ADD_123, 0, 2'b10, '0); step();
        chk("pre_reset_A", A, 64'd9);
        do_reset();
        set_idle(); issue(ADD_123, 0, 2'b10, '0); step();
        chk("post_reset_A", A, 64'd0);
        chk("post_reset_B", B, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                set_idle();
                do_reset();
            end
            ins = $urandom;
            ins[9:5]   = pick_idx();
            ins[20:16] = pick_idx();
            ins[4:0]   = pick_idx();
            in_valid    = ($urandom_range(0, 9) < 7);
            Instruction = ins;
            Reg2Loc     = 1'($urandom);
            ALUSrc      = 1'($urandom);
            ALUOp_in    = 2'($urandom);
            SignExt_imm = {$urandom, $urandom};
            flush       = ($urandom_range(0, 9) == 0);
            out_ready   = ($urandom_range(0, 9) < 6);
            RegWrite    = 1'($urandom);
            WriteReg    = pick_idx();
            WriteData   = {$urandom, $urandom};
            step();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
